os_sort_pipe: RTL and testbench
===============================

OS_SORT_PIPE -- requirements
Module: os_sort_pipe

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bit width of one sample.
REQ-002 SHALL have parameter N, default 9: samples per window; legal range 2..32.
REQ-003 SHALL have parameter RW, default $clog2(N): width of rank_sel.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port arstn, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1: din and rank_sel are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a window this cycle.
REQ-008 SHALL have port din, input, N*DATA_WIDTH: window; sample i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port rank_sel, input, RW: requested rank; 0 = minimum, N-1 = maximum.
REQ-010 SHALL have port out_valid, output, 1: dout and sorted hold a result.
REQ-011 SHALL have port out_ready, input, 1: downstream consumes the result this cycle.
REQ-012 SHALL have port dout, output, DATA_WIDTH: sample of the selected rank.
REQ-013 SHALL have port sorted, output, N*DATA_WIDTH: full window in ascending order; index 0 is the smallest.

Function
REQ-014 SHALL sort with an odd-even transposition network of N register stages, numbered s = 0..N-1.
REQ-015 Stage s SHALL compare-exchange pairs (i, i+1): i even when s is even, i odd when s is odd; unpaired lanes pass through.
REQ-016 Compare-exchange SHALL swap only when lane i > lane i+1 (strict); equal values keep their lane order.
REQ-017 Each stage SHALL carry a valid bit and the rank_sel captured with its window.
REQ-018 Pipeline advance SHALL be global: adv = ~out_valid | out_ready; in_ready = adv.
REQ-019 When adv = 1, every stage SHALL load from its predecessor; stage 0 SHALL load din, rank_sel and in_valid.
REQ-020 When adv = 0, all stage data, valid bits and ranks SHALL hold.
REQ-021 Latency SHALL be N cycles from acceptance (in_valid & in_ready) to out_valid, with no stalls.
REQ-022 Throughput SHALL be one window per cycle while out_ready = 1.
REQ-023 dout SHALL be sorted lane min(rank, N-1) of the final stage; a rank_sel >= N clamps to N-1.
REQ-024 Bubbles (in_valid = 0 on an advance) SHALL propagate as invalid stages; the data in invalid stages is don't-care.
REQ-025 out_valid SHALL equal the final-stage valid bit; dout and sorted SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-026 A window accepted while the output stalls SHALL NOT be lost or duplicated.

Reset
REQ-027 On arstn low, all valid bits SHALL clear immediately: out_valid = 0, in_ready = 1.
REQ-028 On arstn low, all stage data and ranks SHALL clear, so dout = 0 and sorted = 0.
REQ-029 On reset mid-operation, all in-flight windows SHALL be discarded; the first window accepted after release SHALL emerge N cycles later.

Configuration
REQ-030 Macro OS_SORT_SIGNED_EN SHALL select the comparison type.
REQ-031 When OS_SORT_SIGNED_EN is defined, comparisons SHALL treat samples as two's-complement signed.
REQ-032 When OS_SORT_SIGNED_EN is undefined, comparisons SHALL be unsigned; this is the default.

Verification (DATA_WIDTH = 8, N = 5, unsigned unless noted)
REQ-033 Basic sort: din = {7,3,9,1,5} (sample 0 first), rank_sel = 2, out_ready = 1 -> after 5 cycles out_valid = 1, dout = 5, sorted = {1,3,5,7,9}.
REQ-034 Back-to-back with ranks: windows {5,4,3,2,1} with rank 0, then {2,2,8,8,0} with rank 4, then rank 7 on {1,2,3,4,5} -> consecutive outputs 1, 8, 5 (rank 7 clamped to 4).
REQ-035 Backpressure: hold out_ready = 0 for 3 cycles while out_valid = 1 and in_valid = 1 -> in_ready = 0, dout and sorted stable; after release, every window appears exactly once, in order.
REQ-036 Reset mid-flight: assert arstn low with 3 windows in flight -> out_valid = 0 and dout = 0 immediately; after release, no stale window emerges.
REQ-037 Signed build with OS_SORT_SIGNED_EN defined: din = {0x80,0x7F,0x00,0xFF,0x01}, rank 0 -> dout = 0x80; same stimulus unsigned build -> dout = 0x00.
REQ-038 Bubbles: in_valid alternates 1/0 with out_ready = 1 -> out_valid alternates with the same pattern, delayed 5 cycles.

Source files
------------

// File: rtl/os_sort_pipe.sv
// os_sort_pipe -- pipelined order-statistic sorter.
//
// Sorts an N-sample window with an odd-even transposition network of N
// registered stages. It returns the full ascending window and the sample
// at a requested rank.
//
// Parameters
//   DATA_WIDTH  bit width of one sample
//   N           samples per window (2..32)
//   RW          width of rank_sel
//
// Ports
//   clk        rising-edge clock
//   arstn      asynchronous active-low reset
//   in_valid   din / rank_sel valid this cycle
//   in_ready   window accepted this cycle when in_valid is high
//   din        window; sample i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rank_sel   requested rank, 0 = minimum; values >= N clamp to N-1
//   out_valid  dout / sorted hold a result
//   out_ready  downstream consumes the result this cycle
//   dout       sample of the selected rank
//   sorted     ascending window; index 0 is the smallest
//
// Build option
//   OS_SORT_SIGNED_EN  defined: samples compare as two's-complement signed.
//                      undefined (default): samples compare as unsigned.

module os_sort_pipe #(
  parameter int DATA_WIDTH = 8,
  parameter int N          = 9,
  parameter int RW         = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N*DATA_WIDTH-1:0] din,
  input  logic [RW-1:0]         rank_sel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [N*DATA_WIDTH-1:0] sorted
);

  typedef logic [N-1:0][DATA_WIDTH-1:0] win_t;

  win_t          stage_q [N];
  win_t          stage_d [N];
  logic [RW-1:0] rank_q  [N];
  logic [N-1:0]  valid_q;
  logic          adv;
  logic [RW-1:0] sel;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b);
`ifdef OS_SORT_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // A single global advance keeps every stage in lockstep. A stalled output
  // therefore freezes the whole pipe, and no window can be overwritten.
  assign adv       = ~out_valid | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[N-1];
  assign sorted    = stage_q[N-1];

  // Each stage registers its predecessor after one round of compare-exchange.
  // Even stages pair lanes (0,1),(2,3)...; odd stages pair (1,2),(3,4)...
  // The pairs within a stage are disjoint, so swapping in place is safe.
  // The swap is strict, so equal samples keep their lane order.
  always_comb begin
    logic [DATA_WIDTH-1:0] tmp;
    tmp        = '0;
    stage_d[0] = win_t'(din);
    for (int s = 1; s < N; s++) begin
      stage_d[s] = stage_q[s-1];
    end
    for (int s = 0; s < N; s++) begin
      for (int i = 0; i < N - 1; i++) begin
        if (((i % 2) == (s % 2)) && greater(stage_d[s][i], stage_d[s][i+1])) begin
          tmp              = stage_d[s][i];
          stage_d[s][i]    = stage_d[s][i+1];
          stage_d[s][i+1]  = tmp;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      valid_q <= '0;
      for (int s = 0; s < N; s++) begin
        stage_q[s] <= '0;
        rank_q[s]  <= '0;
      end
    end else if (adv) begin
      valid_q   <= {valid_q[N-2:0], in_valid};
      rank_q[0] <= rank_sel;
      for (int s = 0; s < N; s++) begin
        stage_q[s] <= stage_d[s];
      end
      for (int s = 1; s < N; s++) begin
        rank_q[s] <= rank_q[s-1];
      end
    end
  end

  // Ranks beyond the window select the maximum.
  always_comb begin
    sel = rank_q[N-1];
    if (int'(rank_q[N-1]) > N - 1) begin
      sel = RW'(N - 1);
    end
  end

  assign dout = stage_q[N-1][sel];

endmodule

// File: tb/tb_os_sort_pipe.sv
module tb_os_sort_pipe;

  localparam int DW = 8;
  localparam int NS = 5;
  localparam int RWB = $clog2(NS);

  logic              clk = 1'b0;
  logic              arstn;
  logic              in_valid;
  logic              in_ready;
  logic [NS*DW-1:0]  din;
  logic [RWB-1:0]    rank_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     dout;
  logic [NS*DW-1:0]  sorted;

  os_sort_pipe #(.DATA_WIDTH(DW), .N(NS)) dut (
    .clk(clk), .arstn(arstn), .in_valid(in_valid), .in_ready(in_ready),
    .din(din), .rank_sel(rank_sel), .out_valid(out_valid),
    .out_ready(out_ready), .dout(dout), .sorted(sorted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0]    d;
    logic [NS*DW-1:0] s;
    int               acc;
    bit               lat;
  } ent_t;

  ent_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  logic ov_hist [0:1023];

  logic [NS*DW-1:0] vin  [10];
  logic [RWB-1:0]   vrk  [10];
  logic [NS*DW-1:0] vsrt [10];
  logic [DW-1:0]    vdo  [10];

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (cyc < 1024) ov_hist[cyc] <= out_valid;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic [NS*DW-1:0] pk(input int a0, input int a1, input int a2,
                                          input int a3, input int a4);
    return {DW'(a4), DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  task automatic set_vec(input int k, input logic [NS*DW-1:0] w, input int r,
                         input logic [NS*DW-1:0] s, input int d);
    vin[k]  = w;
    vrk[k]  = RWB'(r);
    vsrt[k] = s;
    vdo[k]  = DW'(d);
  endtask

  // Scoreboard monitor: a result is consumed at the next rising edge.
  always @(negedge clk) begin
    if (arstn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {56'd0, dout}, 64'hDEAD);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("dout", {56'd0, dout}, {56'd0, e.d});
        chk("sorted", {24'd0, sorted}, {24'd0, e.s});
        if (e.lat) chk("latency", 64'(cyc - e.acc), 64'd5);
      end
    end
  end

  task automatic send(input int v, input bit lat);
    int guard;
    bit ok;
    in_valid = 1'b1;
    din      = vin[v];
    rank_sel = vrk[v];
    guard    = 0;
    ok       = 1'b0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      if (ok) sb.push_back('{vdo[v], vsrt[v], cyc, lat});
      @(posedge clk);
      #1;
      guard++;
      if (!ok && guard > 50) begin
        chk("send_timeout", 64'd0, 64'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c0;
    int idx [3];
    logic [DW-1:0]    cap_d;
    logic [NS*DW-1:0] cap_s;

    set_vec(0, pk(7,3,9,1,5), 2, pk(1,3,5,7,9), 5);
    set_vec(1, pk(5,4,3,2,1), 0, pk(1,2,3,4,5), 1);
    set_vec(2, pk(2,2,8,8,0), 4, pk(0,2,2,8,8), 8);
    set_vec(3, pk(1,2,3,4,5), 7, pk(1,2,3,4,5), 5);
`ifdef OS_SORT_SIGNED_EN
    set_vec(4, pk(8'h80,8'h7F,8'h00,8'hFF,8'h01), 0, pk(8'h80,8'hFF,8'h00,8'h01,8'h7F), 8'h80);
`else
    set_vec(4, pk(8'h80,8'h7F,8'h00,8'hFF,8'h01), 0, pk(8'h00,8'h01,8'h7F,8'h80,8'hFF), 8'h00);
`endif
    set_vec(5, pk(200,10,200,10,100), 3, pk(10,10,100,200,200), 200);
    set_vec(6, pk(9,9,9,9,9), 1, pk(9,9,9,9,9), 9);
    set_vec(7, pk(255,0,128,64,32), 1, pk(0,32,64,128,255), 32);
    set_vec(8, pk(3,1,4,1,5), 5, pk(1,1,3,4,5), 5);
    set_vec(9, pk(0,0,0,0,1), 4, pk(0,0,0,0,1), 1);

    arstn     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    din       = '0;
    rank_sel  = '0;
    #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_dout", {56'd0, dout}, 64'd0);
    chk("rst_sorted", {24'd0, sorted}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    arstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic sort
    send(0, 1'b1);
    drain();

    // Back-to-back windows with different ranks, including a clamped rank
    send(1, 1'b1);
    send(2, 1'b1);
    send(3, 1'b1);
    drain();

    // Signed / unsigned comparison vector
    send(4, 1'b1);
    drain();

    // Backpressure: stall the output for 3 cycles while input keeps offering
    fork
      begin
        send(5, 1'b0); send(6, 1'b0); send(7, 1'b0); send(8, 1'b0);
        send(9, 1'b0); send(1, 1'b0); send(2, 1'b0);
      end
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!out_valid && g < 40);
        chk("bp_out_valid_seen", {63'd0, out_valid}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        cap_d = dout;
        cap_s = sorted;
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        chk("bp_in_valid_high", {63'd0, in_valid}, 64'd1);
        repeat (2) begin
          @(negedge clk);
          chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
          chk("bp_out_valid_hold", {63'd0, out_valid}, 64'd1);
          chk("bp_dout_stable", {56'd0, dout}, {56'd0, cap_d});
          chk("bp_sorted_stable", {24'd0, sorted}, {24'd0, cap_s});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Bubbles: in_valid alternates 1/0
    idx[0] = 6; idx[1] = 7; idx[2] = 8;
    c0 = 0;
    for (int k = 0; k < 6; k++) begin
      in_valid = (k % 2 == 0);
      din      = vin[idx[k/2]];
      rank_sel = vrk[idx[k/2]];
      @(negedge clk);
      if (k == 0) c0 = cyc;
      if (in_valid && in_ready) sb.push_back('{vdo[idx[k/2]], vsrt[idx[k/2]], cyc, 1'b1});
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("bubble_out_valid", {63'd0, ov_hist[c0+5+k]}, (k % 2 == 0) ? 64'd1 : 64'd0);
    end

    // Reset with windows in flight
    out_ready = 1'b0;
    send(7, 1'b1);
    send(8, 1'b1);
    send(9, 1'b1);
    begin
      int g;
      g = 0;
      do begin
        @(negedge clk);
        g++;
      end while (!out_valid && g < 40);
      chk("rstmid_out_valid_before", {63'd0, out_valid}, 64'd1);
      chk("rstmid_dout_before", {56'd0, dout}, 64'd32);
    end
    #2;
    arstn = 1'b0;
    #1;
    chk("rstmid_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rstmid_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rstmid_dout", {56'd0, dout}, 64'd0);
    chk("rstmid_sorted", {24'd0, sorted}, 64'd0);
    sb.delete();
    @(negedge clk);
    arstn     = 1'b1;
    out_ready = 1'b1;
    repeat (12) @(negedge clk);
    @(posedge clk);
    #1;
    send(0, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
